// File: rtl/write_behind_buf.sv
// write_behind_buf: write-side companion buffer between a producer and a FIFO
// write port. A write passes straight through to the FIFO when nothing is
// parked and the FIFO can take it. Otherwise it is parked in a small ring
// buffer, and parked words drain to the FIFO in order. The full flag is
// registered and asserts one entry early. A producer that drives w_req from a
// single always_ff testing ~full therefore never overflows the buffer.
//
// Ports:
//   clk          clock
//   arst         asynchronous reset, active-high
//   w_req        producer write request
//   w_data       producer write data, valid with w_req
//   full         registered full flag to the producer (1 during reset)
//   err_overflow sticky flag, set when a write is dropped
//   fifo_w_req   write strobe to the downstream FIFO (combinational)
//   fifo_w_data  write data to the downstream FIFO (0 when no strobe)
//   fifo_full    downstream FIFO full flag, sampled combinationally
module write_behind_buf #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              w_req,
  input  logic [DATA_W-1:0] w_data,
  output logic              full,
  output logic              err_overflow,
  output logic              fifo_w_req,
  output logic [DATA_W-1:0] fifo_w_data,
  input  logic              fifo_full
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULLTH = CNT_W'(BUF_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_W-1:0] r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_full;
  logic              r_err;

  logic              w_empty;
  logic              w_at_max;
  logic              w_bypass;
  logic              w_drain;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [PTR_W-1:0]  w_wr_ptr_next;

  // Transfer decisions. Everything is gated by ~arst, so the FIFO side never
  // sees a strobe while reset is held.
  always_comb begin
    w_empty  = (r_cnt == '0);
    w_at_max = (r_cnt == CNT_MAX);
    w_bypass = ~arst & w_empty & ~fifo_full & w_req;
    w_drain  = ~arst & ~w_empty & ~fifo_full;
    // A push into a full buffer is legal only when a drain frees a slot on
    // the same edge.
    w_push   = ~arst & w_req & ~w_bypass & (~w_at_max | w_drain);
    w_drop   = ~arst & w_req & w_at_max & ~w_drain;
  end

  // Post-edge occupancy and pointer advance (pointers wrap modulo BUF_DEPTH).
  always_comb begin
    w_cnt_next    = r_cnt;
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    if (w_push && !w_drain) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else if (w_drain && !w_push) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
    if (w_drain) begin
      w_rd_ptr_next = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
    end
    if (w_push) begin
      w_wr_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
    end
  end

  // Occupancy, pointers, the early full flag and the sticky overflow bit.
  // The full flag asserts with one entry spare. That spare entry absorbs the
  // extra write a registered producer issues before it sees full.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_full   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_full   <= (w_cnt_next >= CNT_FULLTH);
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // Ring buffer storage.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      r_buf[r_wr_ptr] <= w_data;
    end
  end

  // FIFO-side mux. Only the bypass word or a written entry is ever presented.
  always_comb begin
    fifo_w_req  = w_bypass | w_drain;
    fifo_w_data = '0;
    if (w_bypass) begin
      fifo_w_data = w_data;
    end else if (w_drain) begin
      fifo_w_data = r_buf[r_rd_ptr];
    end
  end

  assign full         = r_full;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_write_behind_buf.sv
// Scoreboard bench for write_behind_buf. The stimulus pushes expected FIFO
// words into exp_q. A monitor on the falling edge pops from exp_q and compares
// whenever fifo_w_req is high. The stimulus also performs direct checks of
// flags and same-cycle data.
module tb_write_behind_buf;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          arst;
  logic          w_req;
  logic [DW-1:0] w_data;
  logic          full;
  logic          err_overflow;
  logic          fifo_w_req;
  logic [DW-1:0] fifo_w_data;
  logic          fifo_full;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];

  write_behind_buf #(.DATA_W(DW), .BUF_DEPTH(4)) dut (
    .clk          (clk),
    .arst         (arst),
    .w_req        (w_req),
    .w_data       (w_data),
    .full         (full),
    .err_overflow (err_overflow),
    .fifo_w_req   (fifo_w_req),
    .fifo_w_data  (fifo_w_data),
    .fifo_full    (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every FIFO strobe must match the next expected word.
  always @(negedge clk) begin
    if (fifo_w_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=%h expected=none @%0t",
                 fifo_w_data, $time);
      end else begin
        chk("sb_data", fifo_w_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] words [3];
    logic          pf;
    int            idx;

    arst = 1'b1; w_req = 1'b0; w_data = '0; fifo_full = 1'b0;
    #2;
    // Reset state; the strobe stays gated even with a request present.
    chk("rst_full", DW'(full), 32'd1);
    chk("rst_err", DW'(err_overflow), 32'd0);
    w_req = 1'b1; w_data = 32'hFFFF_0000;
    #1;
    chk("rst_gate_req", DW'(fifo_w_req), 32'd0);
    chk("rst_gate_data", fifo_w_data, 32'd0);
    w_req = 1'b0;
    step();
    #2 arst = 1'b0;
    step();
    chk("rel_full", DW'(full), 32'd0);

    // Bypass: five writes with the FIFO free go straight through.
    for (int i = 0; i < 5; i++) begin
      w_req = 1'b1; w_data = 32'h10 + DW'(i);
      exp_q.push_back(w_data);
      #1;
      chk("byp_req", DW'(fifo_w_req), 32'd1);
      chk("byp_data", fifo_w_data, 32'h10 + DW'(i));
      step();
      chk("byp_full", DW'(full), 32'd0);
    end
    w_req = 1'b0;
    step();

    // Backpressure with a registered producer that tests ~full each edge.
    words[0] = 32'hA0; words[1] = 32'hA1; words[2] = 32'hA2;
    fifo_full = 1'b1;
    idx = 0;
    pf  = full;
    for (int c = 0; c < 6; c++) begin
      if (!pf && idx < 3) begin
        w_req = 1'b1; w_data = words[idx];
        exp_q.push_back(w_data);
        idx++;
      end else begin
        w_req = 1'b0;
      end
      @(negedge clk);
      pf = full;
      step();
      chk("bp_full", DW'(full), (c >= 2) ? 32'd1 : 32'd0);
    end
    chk("bp_count", DW'(idx), 32'd3);
    chk("bp_err", DW'(err_overflow), 32'd0);
    w_req = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_drain_req", DW'(fifo_w_req), 32'd1);
      chk("bp_drain_data", fifo_w_data, words[i]);
      step();
    end
    chk("bp_idle", DW'(fifo_w_req), 32'd0);
    chk("bp_full_clr", DW'(full), 32'd0);

    // Ordering across the fifo_full fall: 0xB2 must queue behind 0xB0/0xB1.
    fifo_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w_req = 1'b1; w_data = 32'hB0 + DW'(i);
      exp_q.push_back(w_data);
      step();
    end
    fifo_full = 1'b0; w_req = 1'b1; w_data = 32'hB2;
    exp_q.push_back(w_data);
    #1;
    chk("ord_head", fifo_w_data, 32'hB0);
    step();
    w_req = 1'b0;
    step();
    step();
    step();
    chk("ord_idle", DW'(fifo_w_req), 32'd0);

    // Full buffer: push together with a drain, then a forced overflow.
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_req = 1'b1; w_data = 32'hC0 + DW'(i);
      exp_q.push_back(w_data);
      step();
    end
    chk("c4_full", DW'(full), 32'd1);
    fifo_full = 1'b0; w_req = 1'b1; w_data = 32'hC4;
    exp_q.push_back(w_data);
    #1;
    chk("c4_drain_data", fifo_w_data, 32'hC0);
    step();
    chk("c4_err", DW'(err_overflow), 32'd0);
    chk("c4_full_after", DW'(full), 32'd1);
    fifo_full = 1'b1; w_req = 1'b1; w_data = 32'hDD;
    step();
    chk("ovf_err", DW'(err_overflow), 32'd1);
    w_req = 1'b0;
    step();
    chk("ovf_sticky", DW'(err_overflow), 32'd1);
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ovf_drain_data", fifo_w_data, 32'hC1 + DW'(i));
      step();
    end
    chk("ovf_idle", DW'(fifo_w_req), 32'd0);
    chk("ovf_sticky2", DW'(err_overflow), 32'd1);

    // Reset in the middle of a drain.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_req = 1'b1; w_data = 32'hE0 + DW'(i);
      exp_q.push_back(w_data);
      step();
    end
    w_req = 1'b0;
    fifo_full = 1'b0;
    #2;
    arst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_req", DW'(fifo_w_req), 32'd0);
    chk("mid_rst_full", DW'(full), 32'd1);
    chk("mid_rst_err", DW'(err_overflow), 32'd0);
    step();
    step();
    #2 arst = 1'b0;
    step();
    chk("post_rst_full", DW'(full), 32'd0);
    w_req = 1'b1; w_data = 32'hF0;
    exp_q.push_back(w_data);
    #1;
    chk("post_rst_byp_req", DW'(fifo_w_req), 32'd1);
    chk("post_rst_byp_data", fifo_w_data, 32'hF0);
    step();
    w_req = 1'b0;
    step();
    step();

    chk("sb_leftover", DW'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/write_behind_buf.md
Name: write_behind_buf

Overview:
- Write-side companion buffer placed between a producer and a FIFO write port.
- Accepts producer writes in the same cycle as w_req and passes them to the FIFO combinationally when possible.
- Parks writes in a small internal ring buffer when the FIFO is full, then drains them in order.
- Provides a registered, early-asserting full flag, so the producer can drive w_req from a single always_ff block that tests ~full without ever overflowing.

Parameters:
- DATA_W, 32: data word width.
- BUF_DEPTH, 4: skid buffer entries; legal range 2..16.

Ports:
- clk  input  1  clock.
- arst  input  1  asynchronous reset, active-high.
- w_req  input  1  producer write request.
- w_data  input  DATA_W  producer write data, valid with w_req.
- full  output  1  registered full flag to producer.
- err_overflow  output  1  sticky; set when a write is dropped.
- fifo_w_req  output  1  write strobe to the downstream FIFO.
- fifo_w_data  output  DATA_W  write data to the downstream FIFO.
- fifo_full  input  1  downstream FIFO full flag.

Behaviour:
- One clock, clk; reset is asynchronous and active-high, arst; all state resets asynchronously.
- Reset values:
  - cnt=0; rd_ptr=0; wr_ptr=0.
  - full=1, deasserting on the first clk edge after arst falls.
  - err_overflow=0.
  - fifo_w_req=0; it is gated by ~arst.
  - fifo_w_data=0 whenever fifo_w_req=0.
- State: ring buffer of BUF_DEPTH words, read/write pointers of $clog2(BUF_DEPTH) bits wrapping modulo BUF_DEPTH, occupancy cnt of $clog2(BUF_DEPTH+1) bits.
- Bypass (zero latency): cnt==0 && ~fifo_full && w_req -> fifo_w_req=1, fifo_w_data=w_data in the same cycle; nothing stored.
- Drain: cnt>0 && ~fifo_full -> fifo_w_req=1, fifo_w_data=buf[rd_ptr]; rd_ptr++ and cnt-- at the clock edge.
- Bypass and drain are mutually exclusive by construction.
- Push: w_req && ~bypass -> buf[wr_ptr]<=w_data, wr_ptr++, cnt++.
  - Ordering is strict FIFO: while cnt>0, new writes always go to the tail, never bypass.
- Simultaneous push and drain: cnt is unchanged and both pointers advance. This is legal at cnt==BUF_DEPTH, because the drain frees a slot in the same edge and no overflow occurs.
- Overflow: w_req && cnt==BUF_DEPTH && ~drain -> word dropped; pointers and cnt unchanged; err_overflow<=1 until reset.
- Full flag:
  - full <= (cnt_next >= BUF_DEPTH-1), where cnt_next is the post-edge occupancy.
  - The one-entry margin covers the producer's one-cycle registered reaction: a write already in flight plus one more write decided on a stale ~full.
  - Consequence: no overflow under the single-always_ff producer pattern.
- fifo_full is sampled combinationally. Its rise blocks bypass and drain in the same cycle.
- Reset mid-operation: buffered words are discarded; the FIFO side sees no strobe while arst=1.
- No X propagation: unwritten buffer entries are never presented on fifo_w_data.

Decomposition:
- No package; all widths derive locally from the parameters via $clog2.
- Single module, no sub-module. The ring buffer is a plain register array inside the block.
- The full-flag register and the err_overflow sticky bit live in the same always_ff as cnt.

Test Plan:
- Bypass: fifo_full=0, w_req for 5 cycles, data 0x10..0x14 -> fifo_w_req high in the same 5 cycles, data 0x10..0x14 in order, cnt stays 0, full stays 0.
- Backpressure: fifo_full=1, producer writes 0xA0, 0xA1, 0xA2 using the always_ff ~full pattern.
  - Required: cnt 1,2,3; full rises after cnt_next reaches 3; producer stops; err_overflow=0.
  - Then fifo_full=0 -> 0xA0, 0xA1, 0xA2 emitted on three consecutive cycles.
- Order across the transition: cnt=2 holding 0xB0, 0xB1; fifo_full falls while w_req carries 0xB2 -> FIFO receives 0xB0, 0xB1, 0xB2, with no bypass of 0xB2.
- Full-buffer push with drain: cnt=4, fifo_full=0, w_req 0xC4 -> 0xC0 drained, 0xC4 stored, cnt stays 4, err_overflow=0.
- Forced overflow: cnt=4, fifo_full=1, w_req 0xDD -> 0xDD dropped, err_overflow=1 and sticky; later drain outputs the four original words only.
- Reset mid-drain: cnt=3, assert arst asynchronously between edges.
  - Required: fifo_w_req=0 immediately, full=1, err_overflow=0.
  - After release: full=0 on the first edge, and the next write bypasses.
